// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter and sequencer sharing one spi_master between NUM_REQ requesters.
// Each granted request is launched, tracked to completion and answered with data or an error.
module spi_master_arbiter #(
   parameter  int NUM_REQ       = 4,
   parameter  int DATA_WIDTH    = 32,
   parameter  int ADDRESS_WIDTH = 32,
   parameter  int START_TIMEOUT = 64,
   localparam int IDW           = $clog2(NUM_REQ)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_rd_we,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   input  logic [NUM_REQ*16-1:0]            req_divider,
   input  logic [NUM_REQ-1:0]               req_cpha,
   input  logic [NUM_REQ-1:0]               req_cpol,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic                             rsp_error,
   output logic [IDW-1:0]                   grant_id,
   output logic                             active,
   output logic                             spi_enable,
   output logic                             spi_rd_we,
   output logic [ADDRESS_WIDTH-1:0]         spi_address,
   output logic [DATA_WIDTH-1:0]            spi_data,
   output logic [15:0]                      spi_divider,
   output logic                             spi_clock_phase,
   output logic                             spi_clock_polarity,
   input  logic                             spi_busy,
   input  logic                             spi_data_read_valid,
   input  logic [DATA_WIDTH-1:0]            spi_data_read
);

   localparam int SW = IDW + 1;
   localparam int CW = $clog2(START_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_START,
      S_WAIT_DONE,
      S_RESP
   } state_t;

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [CW-1:0]    wait_cnt;
   logic             rd_seen;

   logic [NUM_REQ-1:0]       rot;
   logic [SW-1:0]            sum;
   logic [IDW-1:0]           pick;
   logic                     pick_valid;
   logic                     sel_rd_we;
   logic [ADDRESS_WIDTH-1:0] sel_address;
   logic [DATA_WIDTH-1:0]    sel_data;
   logic [15:0]              sel_divider;
   logic                     sel_cpha;
   logic                     sel_cpol;

   // Rotate so bit 0 is the requester at ptr; the lowest set bit after rotation wins.
   // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
   always_comb begin
      rot        = NUM_REQ'({req_valid, req_valid} >> ptr);
      sum        = '0;
      pick       = '0;
      pick_valid = 1'b0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            sum        = {1'b0, ptr} + SW'(j);
            pick       = (sum >= SW'(NUM_REQ)) ? IDW'(sum - SW'(NUM_REQ)) : IDW'(sum);
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin
      sel_rd_we   = 1'b0;
      sel_address = '0;
      sel_data    = '0;
      sel_divider = '0;
      sel_cpha    = 1'b0;
      sel_cpol    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick == IDW'(i)) begin
            sel_rd_we   = req_rd_we[i];
            sel_address = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            sel_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_divider = req_divider[i*16 +: 16];
            sel_cpha    = req_cpha[i];
            sel_cpol    = req_cpol[i];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= S_IDLE;
         ptr                <= '0;
         wait_cnt           <= '0;
         rd_seen            <= 1'b0;
         req_ready          <= '0;
         rsp_valid          <= '0;
         rsp_data           <= '0;
         rsp_error          <= 1'b0;
         grant_id           <= '0;
         active             <= 1'b0;
         spi_enable         <= 1'b0;
         spi_rd_we          <= 1'b0;
         spi_address        <= '0;
         spi_data           <= '0;
         spi_divider        <= 16'd2;
         spi_clock_phase    <= 1'b0;
         spi_clock_polarity <= 1'b0;
      end else begin
         req_ready  <= '0;
         rsp_valid  <= '0;
         spi_enable <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  req_ready          <= NUM_REQ'(1) << pick;
                  grant_id           <= pick;
                  active             <= 1'b1;
                  spi_rd_we          <= sel_rd_we;
                  spi_address        <= sel_address;
                  spi_data           <= sel_data;
                  spi_divider        <= sel_divider;
                  spi_clock_phase    <= sel_cpha;
                  spi_clock_polarity <= sel_cpol;
                  state              <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               spi_enable <= 1'b1;
               wait_cnt   <= '0;
               rd_seen    <= 1'b0;
               state      <= S_WAIT_START;
            end
            S_WAIT_START: begin
               // The count starts in the enable cycle, so the response lands START_TIMEOUT+2 after accept.
               if (spi_busy) begin
                  state <= S_WAIT_DONE;
               end else if (wait_cnt == CW'(START_TIMEOUT)) begin
                  rsp_error <= 1'b1;
                  rsp_valid <= NUM_REQ'(1) << grant_id;
                  state     <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            S_WAIT_DONE: begin
               if (spi_data_read_valid && !spi_rd_we) begin
                  rsp_data <= spi_data_read;
                  rd_seen  <= 1'b1;
               end
               if (!spi_busy) begin
                  rsp_error <= !spi_rd_we && !(rd_seen || spi_data_read_valid);
                  rsp_valid <= NUM_REQ'(1) << grant_id;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               ptr    <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
               active <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
